// File: rtl/softmax_out_serializer_if.sv
// Stream bundle between the softmax pipeline, the serializer and the downstream
// consumer: the wide capture side plus the 16-bit beat side.
interface softmax_out_serializer_if;
  logic          i_valid;
  logic [1023:0] i_prob_flat;
  logic [1:0]    i_length_mode;
  logic          i_ready;
  logic          o_valid;
  logic [15:0]   o_data;
  logic [5:0]    o_lane;
  logic          o_last;
  logic          o_vec_last;

  // Serializer view: receives vectors and ready, produces beats
  modport slave (
    input  i_valid, i_prob_flat, i_length_mode, i_ready,
    output o_valid, o_data, o_lane, o_last, o_vec_last
  );

  // Driver/consumer view: the opposite directions
  modport master (
    output i_valid, i_prob_flat, i_length_mode, i_ready,
    input  o_valid, o_data, o_lane, o_last, o_vec_last
  );
endinterface

// File: rtl/softmax_out_serializer.sv
// Softmax output serializer: buffers up to FIFO_DEPTH 64-lane probability
// vectors (the pipeline cannot be stalled) and replays each one as 64 beats of
// 16 bits, flagging row ends according to the length mode captured with it.
module softmax_out_serializer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_en,
  input  logic                        i_clr_ovf,
  softmax_out_serializer_if.slave     io_stream,
  output logic [$clog2(FIFO_DEPTH):0] o_count,
  output logic                        o_full,
  output logic                        o_empty,
  output logic                        o_overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {S_EMPTY, S_STREAM} state_t;

  state_t        r_state;
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_count;
  logic [5:0]    r_lane;
  logic          r_overflow;
  logic [1023:0] r_data [FIFO_DEPTH];
  logic [1:0]    r_mode [FIFO_DEPTH];

  logic          w_full;
  logic          w_empty;
  logic          w_valid;
  logic          w_fire;
  logic          w_pop;
  logic          w_write;
  logic          w_drop;
  logic [1023:0] w_headData;
  logic [1:0]    w_headMode;
  logic          w_last;

  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_valid = (r_state == S_STREAM);
  assign w_fire  = i_en & w_valid & io_stream.i_ready;
  assign w_pop   = w_fire & (r_lane == 6'd63);
  // A full buffer still accepts a vector in the cycle its head slot frees up
  assign w_write = i_en & io_stream.i_valid & (~w_full | w_pop);
  assign w_drop  = i_en & io_stream.i_valid & w_full & ~w_pop;

  // Control FSM: pointers, occupancy, lane counter and sticky overflow flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_EMPTY;
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_lane     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_write) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_pop) begin
        r_lane <= '0;
      end else if (w_fire) begin
        r_lane <= r_lane + 1'b1;
      end
      case (r_state)
        S_EMPTY: begin
          if (w_write) begin
            r_state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_pop && !w_write && (r_count == CW'(1))) begin
            r_state <= S_EMPTY;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (i_en && i_clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Vector storage: one slot written per accepted capture, cleared on reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_data[i] <= '0;
        r_mode[i] <= '0;
      end
    end else if (w_write) begin
      r_data[r_wp] <= io_stream.i_prob_flat;
      r_mode[r_wp] <= io_stream.i_length_mode;
    end
  end

  assign w_headData = r_data[r_rp];
  assign w_headMode = r_mode[r_rp];

  // Row-end flag: row length is 16, 32 or 64 lanes depending on head mode
  always_comb begin
    w_last = 1'b0;
    case (w_headMode)
      2'd0:    w_last = (r_lane[3:0] == 4'hF);
      2'd1:    w_last = (r_lane[4:0] == 5'h1F);
      default: w_last = (r_lane == 6'd63);
    endcase
  end

  assign io_stream.o_valid    = w_valid;
  assign io_stream.o_data     = w_headData[{r_lane, 4'b0000} +: 16];
  assign io_stream.o_lane     = r_lane;
  assign io_stream.o_last     = w_last;
  assign io_stream.o_vec_last = (r_lane == 6'd63);

  assign o_count    = r_count;
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_softmax_out_serializer.sv
// Directed testbench for softmax_out_serializer: table-driven mode checks plus
// hand-written sequences for backpressure, fill/overflow, full-wrap and reset.
module tb_softmax_out_serializer;

  logic       clk;
  logic       rst;
  logic       en;
  logic       clrOvf;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       overflow;

  int errCount;
  int checkCount;

  softmax_out_serializer_if bus ();

  softmax_out_serializer #(.FIFO_DEPTH(4)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_clr_ovf  (clrOvf),
    .io_stream  (bus),
    .o_count    (count),
    .o_full     (full),
    .o_empty    (empty),
    .o_overflow (overflow)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] base;
    logic [63:0] lastMask;
  } vecTest_t;

  vecTest_t vecTable [4];

  localparam logic [63:0] MASK_M0 = 64'h8000_8000_8000_8000;
  localparam logic [63:0] MASK_M1 = 64'h8000_0000_8000_0000;
  localparam logic [63:0] MASK_M2 = 64'h8000_0000_0000_0000;

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [1023:0] mkVec(input logic [15:0] base);
    logic [1023:0] v;
    v = '0;
    for (int k = 0; k < 64; k++) begin
      v[16*k +: 16] = 16'(base + 16'(k));
    end
    return v;
  endfunction

  task automatic applyStimulus(input logic e, input logic v, input logic [15:0] base,
                               input logic [1:0] mode, input logic r, input logic c);
    en                = e;
    bus.i_valid       = v;
    bus.i_prob_flat   = v ? mkVec(base) : '0;
    bus.i_length_mode = mode;
    bus.i_ready       = r;
    clrOvf            = c;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expects the vector at lane 0 on the outputs and i_ready high; consumes 64 beats
  task automatic streamVector(input logic [15:0] base, input logic [63:0] mask, input string tag);
    for (int k = 0; k < 64; k++) begin
      checkOutput({tag, " valid"},    32'(bus.o_valid),    32'd1);
      checkOutput({tag, " lane"},     32'(bus.o_lane),     32'(k));
      checkOutput({tag, " data"},     32'(bus.o_data),     32'(16'(base + 16'(k))));
      checkOutput({tag, " last"},     32'(bus.o_last),     32'(mask[k]));
      checkOutput({tag, " vec_last"}, 32'(bus.o_vec_last), 32'(k == 63));
      @(negedge clk);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " valid"},    32'(bus.o_valid),    32'd0);
    checkOutput({tag, " empty"},    32'(empty),          32'd1);
    checkOutput({tag, " full"},     32'(full),           32'd0);
    checkOutput({tag, " count"},    32'(count),          32'd0);
    checkOutput({tag, " lane"},     32'(bus.o_lane),     32'd0);
    checkOutput({tag, " vec_last"}, 32'(bus.o_vec_last), 32'd0);
    checkOutput({tag, " last"},     32'(bus.o_last),     32'd0);
    checkOutput({tag, " data"},     32'(bus.o_data),     32'd0);
    checkOutput({tag, " overflow"}, 32'(overflow),       32'd0);
  endtask

  // Main test sequence
  initial begin
    int expLane;
    int cyc;
    logic holdDone;
    logic accept;

    errCount   = 0;
    checkCount = 0;
    vecTable[0] = '{mode: 2'd2, base: 16'h0100, lastMask: MASK_M2};
    vecTable[1] = '{mode: 2'd0, base: 16'h1100, lastMask: MASK_M0};
    vecTable[2] = '{mode: 2'd1, base: 16'h2200, lastMask: MASK_M1};
    vecTable[3] = '{mode: 2'd3, base: 16'h3300, lastMask: MASK_M2};

    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 16'h0, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkResetOutputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkResetOutputs("post-reset");

    // Table: one vector per length mode, streamed at full rate
    for (int t = 0; t < 4; t++) begin
      applyStimulus(1'b1, 1'b1, vecTable[t].base, vecTable[t].mode, 1'b1, 1'b0);
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 16'h0, 2'd0, 1'b1, 1'b0);
      checkOutput("table count", 32'(count), 32'd1);
      streamVector(vecTable[t].base, vecTable[t].lastMask, $sformatf("table%0d", t));
      checkOutput("table empty", 32'(empty), 32'd1);
      checkOutput("table valid", 32'(bus.o_valid), 32'd0);
    end

    // Backpressure with toggling ready plus a five-cycle enable hold mid-vector
    applyStimulus(1'b1, 1'b1, 16'h0200, 2'd2, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 16'h0, 2'd0, 1'b0, 1'b0);
    expLane  = 0;
    cyc      = 0;
    holdDone = 1'b0;
    while (expLane < 64 && cyc < 400) begin
      checkOutput("bp valid", 32'(bus.o_valid), 32'd1);
      checkOutput("bp lane",  32'(bus.o_lane),  32'(expLane));
      checkOutput("bp data",  32'(bus.o_data),  32'(16'(16'h0200 + 16'(expLane))));
      if (expLane == 30 && !holdDone) begin
        en          = 1'b0;
        bus.i_ready = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_prob_flat = mkVec(16'hDEAD);
        repeat (5) begin
          @(negedge clk);
          checkOutput("en-hold lane",  32'(bus.o_lane), 32'd30);
          checkOutput("en-hold data",  32'(bus.o_data), 32'(16'h021E));
          checkOutput("en-hold count", 32'(count),      32'd1);
          checkOutput("en-hold ovf",   32'(overflow),   32'd0);
        end
        bus.i_valid = 1'b0;
        en          = 1'b1;
        holdDone    = 1'b1;
      end
      accept      = cyc[0];
      bus.i_ready = accept;
      @(negedge clk);
      if (accept) expLane++;
      cyc++;
    end
    checkOutput("bp all lanes", 32'(expLane), 32'd64);
    checkOutput("bp empty",     32'(empty),   32'd1);

    // Fill four slots with no downstream acceptance, then overflow
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 16'(16'h1000 * (i + 1)), 2'(i), 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("fill count", 32'(count), 32'(i + 1));
    end
    checkOutput("fill full", 32'(full),     32'd1);
    checkOutput("fill ovf",  32'(overflow), 32'd0);
    applyStimulus(1'b1, 1'b1, 16'h5000, 2'd2, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("drop ovf",   32'(overflow), 32'd1);
    checkOutput("drop count", 32'(count),    32'd4);
    applyStimulus(1'b1, 1'b0, 16'h0, 2'd0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("clr ovf", 32'(overflow), 32'd0);
    applyStimulus(1'b1, 1'b1, 16'h5500, 2'd2, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("set beats clr", 32'(overflow), 32'd1);
    applyStimulus(1'b1, 1'b0, 16'h0, 2'd0, 1'b1, 1'b0);
    streamVector(16'h1000, MASK_M0, "drain0");
    streamVector(16'h2000, MASK_M1, "drain1");
    streamVector(16'h3000, MASK_M2, "drain2");
    streamVector(16'h4000, MASK_M2, "drain3");
    checkOutput("drain empty", 32'(empty), 32'd1);
    applyStimulus(1'b1, 1'b0, 16'h0, 2'd0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("clr ovf 2", 32'(overflow), 32'd0);

    // Full buffer accepts a vector in the same cycle its head finishes
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 16'(16'h6000 + 16'h1000 * i), 2'd2, 1'b0, 1'b0);
      @(negedge clk);
    end
    checkOutput("wrap full", 32'(full), 32'd1);
    applyStimulus(1'b1, 1'b0, 16'h0, 2'd0, 1'b1, 1'b0);
    for (int k = 0; k < 64; k++) begin
      checkOutput("wrap head data", 32'(bus.o_data), 32'(16'(16'h6000 + 16'(k))));
      if (k == 63) applyStimulus(1'b1, 1'b1, 16'hA000, 2'd2, 1'b1, 1'b0);
      @(negedge clk);
    end
    applyStimulus(1'b1, 1'b0, 16'h0, 2'd0, 1'b1, 1'b0);
    checkOutput("wrap ovf",   32'(overflow), 32'd0);
    checkOutput("wrap count", 32'(count),    32'd4);
    streamVector(16'h7000, MASK_M2, "wrap1");
    streamVector(16'h8000, MASK_M2, "wrap2");
    streamVector(16'h9000, MASK_M2, "wrap3");
    streamVector(16'hA000, MASK_M2, "wrapnew");
    checkOutput("wrap empty", 32'(empty), 32'd1);

    // Asynchronous reset in the middle of a vector with three entries queued
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 16'(16'hC000 + 16'h0100 * i), 2'd2, 1'b0, 1'b0);
      @(negedge clk);
    end
    applyStimulus(1'b1, 1'b0, 16'h0, 2'd0, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    checkOutput("pre-rst lane",  32'(bus.o_lane), 32'd20);
    checkOutput("pre-rst count", 32'(count),      32'd3);
    #2;
    rst = 1'b1;
    #1;
    checkResetOutputs("async rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkResetOutputs("rst released");
    applyStimulus(1'b1, 1'b1, 16'hB000, 2'd1, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 16'h0, 2'd0, 1'b1, 1'b0);
    streamVector(16'hB000, MASK_M1, "fresh");
    checkOutput("fresh empty", 32'(empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/softmax_out_serializer.md
# softmax_out_serializer

Drain-side companion of the 64-lane softmax approximation pipeline. It captures each 1024-bit probability vector when the pipeline pulses its output valid, and buffers up to FIFO_DEPTH vectors, because the pipeline has no backpressure. It then replays them as a 16-bit-per-beat valid/ready stream, with per-row and per-vector boundary flags derived from the length mode that travels with each vector.

## Interface
- FIFO_DEPTH, 4: vector slots; power of two, ≥2.
- i_clk  in  1  clock; all state on rising edge.
- i_rst  in  1  reset; asynchronous and active-high.
- i_en  in  1  global enable; when low, no capture, no beat transfer, all state held.
- i_valid  in  1  one-cycle pulse; vector present on i_prob_flat.
- i_prob_flat  in  1024  lane k = bits [16k+15:16k], k = 0..63.
- i_length_mode  in  2  row length of the vector, sampled with i_valid: 0 = 16, 1 = 32, 2 or 3 = 64.
- i_ready  in  1  downstream accepts beat.
- o_valid  out  1  beat available.
- o_data  out  16  current lane value.
- o_lane  out  6  index of current lane.
- o_last  out  1  current beat ends a softmax row.
- o_vec_last  out  1  current beat is lane 63.
- o_count  out  $clog2(FIFO_DEPTH)+1  occupied slots.
- o_full  out  1  o_count == FIFO_DEPTH.
- o_empty  out  1  o_count == 0.
- o_overflow  out  1  sticky; a vector was dropped.
- i_clr_ovf  in  1  synchronous clear of o_overflow (qualified by i_en).

## Operation
- Storage: circular buffer of FIFO_DEPTH entries. Each entry holds {mode[1:0], data[1023:0]}, with write pointer wp, read pointer rp, and count. Pointers wrap modulo FIFO_DEPTH.
- Capture: write = i_en & i_valid & (~o_full | pop).
  - On write, the entry at wp is loaded, wp increments and count increments.
  - pop is defined below.
- Overflow: i_en & i_valid & o_full & ~pop drops the vector and sets o_overflow.
  - Set has priority over i_clr_ovf in the same cycle.
  - Stored entries are not affected.
- Lane counter: lane[5:0].
  - A beat transfers when fire = i_en & o_valid & i_ready.
  - On fire, lane increments.
  - pop = fire & (lane == 63). On pop, lane returns to 0, rp increments and count decrements.
- Simultaneous write and pop: count is unchanged and both pointers advance. This is legal when full, so a full buffer accepts a new vector in the cycle its head finishes.
- Output path is combinational from registered state:
  - o_valid = ~o_empty.
  - o_data = head.data[16·lane +: 16].
  - o_lane = lane.
  - o_vec_last = (lane == 63).
  - o_last: mode 0 → lane[3:0] == 15; mode 1 → lane[4:0] == 31; mode 2/3 → lane == 63. Mode is the head entry's mode.
- Control states:
  - EMPTY (count = 0): o_valid low; lane held at 0.
  - STREAM (count > 0): beats issue.
  - EMPTY → STREAM on write. STREAM → EMPTY on pop with count = 1 and no write.
- o_data, o_last and o_lane must stay stable while o_valid & ~i_ready. i_en low also holds them.
- o_data / o_last are don't-care when o_valid is low.

## Timing
- Reset (async assert, takes effect immediately): wp = rp = 0, count = 0, lane = 0, o_overflow = 0. Resulting outputs: o_valid = 0, o_empty = 1, o_full = 0, o_count = 0, o_lane = 0, o_vec_last = 0, o_last = 0, o_data = 0 (storage cleared).
- Reset mid-stream discards all buffered vectors and the partial vector.
- Latency: a vector captured at edge N gives o_valid high and lane 0 on o_data after edge N, provided the buffer was empty.
- Throughput: 64 beats per vector at i_ready = 1, with no bubble between consecutive vectors.
- Pipeline input rate above 1 vector per 64 cycles eventually overflows. This is a system budgeting rule, not checked here.
- i_valid while i_en is low is ignored, and no overflow is flagged.

## Test plan
- Reset, then capture one mode-2 vector with lane k = 16'h0100+k, i_ready = 1 → 64 beats. o_data = 0100..013F, o_lane 0..63, o_last and o_vec_last only on beat 63, then o_empty = 1.
- Mode-0 vector → o_last on lanes 15, 31, 47, 63. Mode-1 vector → o_last on lanes 31, 63. Mode-3 vector → behaves as mode 2.
- Backpressure: toggle i_ready every cycle → each lane is emitted exactly once, in order, with o_data held during stalls. Also hold i_en low for 5 cycles mid-vector → no lane is skipped or repeated.
- Fill 4 vectors with i_ready = 0 → o_full = 1, o_count = 4. A 5th i_valid is dropped, o_overflow = 1, and the 4 stored vectors drain intact. i_clr_ovf → 0. Asserting i_valid and i_clr_ovf together → o_overflow stays 1.
- Full buffer: i_valid in the same cycle as the head's lane-63 accept → accepted, o_overflow = 0, o_count stays 4, and the new vector streams last after correct pointer wrap.
- Assert i_rst asynchronously mid-vector (lane 20, 3 entries) → outputs return to reset values immediately. After release, a fresh vector streams from lane 0.
